// File: rtl/div_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters into one shared LAT-stage divider; results routed back by tag.
// Issue is combinational, result LAT cycles later; a non-ready result owner stalls the whole pipe via div_busy.
module div_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int LAT     = 5,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*N-1:0]       req_dividend,
    input  logic [NUM_REQ*M-1:0]       req_divisor,
    output logic                       div_en,
    output logic                       div_busy,
    output logic [N-1:0]               div_dividend,
    output logic [M-1:0]               div_divisor,
    output logic [TAG_W-1:0]           div_k,
    input  logic                       div_rdy,
    input  logic [N-M:0]               div_quotient,
    input  logic [M-1:0]               div_remainder,
    input  logic [TAG_W-1:0]           div_k_out,
    output logic [NUM_REQ-1:0]         res_valid,
    input  logic [NUM_REQ-1:0]         res_ready,
    output logic [N-M:0]               res_quotient,
    output logic [M-1:0]               res_remainder,
    output logic                       res_dz,
    output logic [$clog2(LAT+1)-1:0]   inflight,
    output logic                       idle
);
    localparam int CNT_W = $clog2(LAT+1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] win;
    logic             found;
    logic             grant;
    logic [LAT-1:0]   sh_v;
    logic [LAT-1:0]   sh_dz;
    logic [TAG_W-1:0] sh_k [LAT];
    logic             out_v;
    logic [TAG_W-1:0] out_k;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    // Shadow pipe is the source of truth for valid/tag; the divider supplies only data.
    assign out_v    = sh_v[LAT-1];
    assign out_k    = sh_k[LAT-1];
    assign div_busy = out_v && !res_ready[out_k];
    assign retire   = out_v && !div_busy;

    assign res_valid     = out_v ? (NUM_REQ'(1) << out_k) : '0;
    assign res_quotient  = div_quotient;
    assign res_remainder = div_remainder;
    assign res_dz        = out_v && sh_dz[LAT-1];

    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = TAG_W'(idx);
            end
        end
    end

    assign grant        = found && !div_busy;
    assign req_ready    = grant ? (NUM_REQ'(1) << win) : '0;
    assign div_en       = grant;
    assign div_k        = grant ? win : '0;
    assign div_dividend = grant ? req_dividend[win*N +: N] : '0;
    assign div_divisor  = grant ? req_divisor[win*M +: M] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win == TAG_W'(NUM_REQ-1)) ? '0 : win + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_v  <= '0;
            sh_dz <= '0;
            for (int i = 0; i < LAT; i++) sh_k[i] <= '0;
        end else if (!div_busy) begin
            sh_v    <= {sh_v[LAT-2:0], div_en};
            sh_dz   <= {sh_dz[LAT-2:0], (div_divisor == '0)};
            sh_k[0] <= div_k;
            for (int i = 1; i < LAT; i++) sh_k[i] <= sh_k[i-1];
        end
    end

    // Issue and retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (div_en && !retire) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!div_en && retire) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign inflight = cnt;
    assign idle     = (cnt == '0) && !(|req_valid);

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Directed bench for div_issue_arbiter with a behavioural 5-stage divider attached.
module tb_div_issue_arbiter;
    localparam int NUM_REQ = 4;
    localparam int N       = 8;
    localparam int M       = 4;
    localparam int LAT     = 5;
    localparam int TAG_W   = 2;
    localparam int QW      = N - M + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_dividend;
    logic [NUM_REQ*M-1:0] req_divisor;
    logic                 div_en, div_busy;
    logic [N-1:0]         div_dividend;
    logic [M-1:0]         div_divisor;
    logic [TAG_W-1:0]     div_k;
    logic                 div_rdy;
    logic [QW-1:0]        div_quotient;
    logic [M-1:0]         div_remainder;
    logic [TAG_W-1:0]     div_k_out;
    logic [NUM_REQ-1:0]   res_valid;
    logic [NUM_REQ-1:0]   res_ready;
    logic [QW-1:0]        res_quotient;
    logic [M-1:0]         res_remainder;
    logic                 res_dz;
    logic [2:0]           inflight;
    logic                 idle;

    div_issue_arbiter #(.NUM_REQ(NUM_REQ), .N(N), .M(M), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_en(div_en), .div_busy(div_busy),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_k(div_k),
        .div_rdy(div_rdy), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_k_out(div_k_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_quotient(res_quotient), .res_remainder(res_remainder),
        .res_dz(res_dz), .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Behavioural divider chain: stalls on div_busy, reset by the same rst_n.
    logic [LAT-1:0]   dv_v;
    logic [TAG_W-1:0] dv_k [LAT];
    logic [QW-1:0]    dv_q [LAT];
    logic [M-1:0]     dv_r [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                dv_k[i] <= '0; dv_q[i] <= '0; dv_r[i] <= '0;
            end
        end else if (!div_busy) begin
            dv_v    <= {dv_v[LAT-2:0], div_en};
            dv_k[0] <= div_k;
            dv_q[0] <= (div_divisor == 0) ? {QW{1'b1}} : QW'(div_dividend / div_divisor);
            dv_r[0] <= (div_divisor == 0) ? div_dividend[M-1:0] : M'(div_dividend % div_divisor);
            for (int i = 1; i < LAT; i++) begin
                dv_k[i] <= dv_k[i-1]; dv_q[i] <= dv_q[i-1]; dv_r[i] <= dv_r[i-1];
            end
        end
    end

    assign div_rdy       = dv_v[LAT-1];
    assign div_k_out     = dv_k[LAT-1];
    assign div_quotient  = dv_q[LAT-1];
    assign div_remainder = dv_r[LAT-1];

    int checks = 0;
    int errors = 0;

    // Divider's last stage must agree with the arbiter's routed result.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (div_rdy !== (|res_valid) || (div_rdy && res_valid !== (4'b0001 << div_k_out))) begin
                errors++;
                $display("FAIL shadow_sync: div_rdy=%0b k_out=%0d res_valid=%b", div_rdy, div_k_out, res_valid);
            end
        end
    end

    typedef struct {
        logic [3:0] rv, rr, gnt;
        logic       en;
        logic [1:0] k;
        logic [3:0] resv;
        logic [4:0] q;
        logic [3:0] r;
        logic       dz, busy;
        logic [2:0] infl;
        logic       idle;
    } vec_t;

    logic [7:0] dvd_t [4];
    logic [3:0] dvs_t [4];
    logic [4:0] qt [4];
    logic [3:0] rt [4];
    vec_t       tbl [22];

    function automatic vec_t mk(logic [3:0] rv, logic [3:0] rr, logic [3:0] gnt, logic en,
                                logic [1:0] k, logic [3:0] resv, logic [4:0] q, logic [3:0] r,
                                logic dz, logic busy, logic [2:0] infl, logic idl);
        vec_t v;
        v.rv = rv; v.rr = rr; v.gnt = gnt; v.en = en; v.k = k; v.resv = resv;
        v.q = q; v.r = r; v.dz = dz; v.busy = busy; v.infl = infl; v.idle = idl;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic repack();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dividend[i*N +: N] = dvd_t[i];
            req_divisor[i*M +: M]  = dvs_t[i];
        end
    endtask

    task automatic apply(vec_t v, string lbl);
        @(negedge clk);
        req_valid = v.rv;
        res_ready = v.rr;
        #1;
        chk($sformatf("%s req_ready", lbl), 32'(req_ready), 32'(v.gnt));
        chk($sformatf("%s div_en", lbl), 32'(div_en), 32'(v.en));
        chk($sformatf("%s div_busy", lbl), 32'(div_busy), 32'(v.busy));
        chk($sformatf("%s res_valid", lbl), 32'(res_valid), 32'(v.resv));
        chk($sformatf("%s res_dz", lbl), 32'(res_dz), 32'(v.dz));
        chk($sformatf("%s inflight", lbl), 32'(inflight), 32'(v.infl));
        chk($sformatf("%s idle", lbl), 32'(idle), 32'(v.idle));
        if (v.en) begin
            chk($sformatf("%s div_k", lbl), 32'(div_k), 32'(v.k));
            chk($sformatf("%s div_dividend", lbl), 32'(div_dividend), 32'(dvd_t[v.k]));
            chk($sformatf("%s div_divisor", lbl), 32'(div_divisor), 32'(dvs_t[v.k]));
        end
        if (v.resv != 4'b0) begin
            chk($sformatf("%s res_quotient", lbl), 32'(res_quotient), 32'(v.q));
            chk($sformatf("%s res_remainder", lbl), 32'(res_remainder), 32'(v.r));
        end
    endtask

    task automatic rst_chk(string lbl);
        chk($sformatf("%s req_ready", lbl), 32'(req_ready), 0);
        chk($sformatf("%s div_en", lbl), 32'(div_en), 0);
        chk($sformatf("%s div_busy", lbl), 32'(div_busy), 0);
        chk($sformatf("%s div_k", lbl), 32'(div_k), 0);
        chk($sformatf("%s div_dividend", lbl), 32'(div_dividend), 0);
        chk($sformatf("%s div_divisor", lbl), 32'(div_divisor), 0);
        chk($sformatf("%s res_valid", lbl), 32'(res_valid), 0);
        chk($sformatf("%s res_quotient", lbl), 32'(res_quotient), 0);
        chk($sformatf("%s res_remainder", lbl), 32'(res_remainder), 0);
        chk($sformatf("%s res_dz", lbl), 32'(res_dz), 0);
        chk($sformatf("%s inflight", lbl), 32'(inflight), 0);
        chk($sformatf("%s idle", lbl), 32'(idle), 1);
    endtask

    initial begin
        int t;
        // Operands per requester and their hand-computed results.
        dvd_t[0] = 8'd200; dvs_t[0] = 4'd7;  qt[0] = 5'd28; rt[0] = 4'd4;
        dvd_t[1] = 8'd100; dvs_t[1] = 4'd9;  qt[1] = 5'd11; rt[1] = 4'd1;
        dvd_t[2] = 8'd63;  dvs_t[2] = 4'd5;  qt[2] = 5'd12; rt[2] = 4'd3;
        dvd_t[3] = 8'd150; dvs_t[3] = 4'd13; qt[3] = 5'd11; rt[3] = 4'd7;
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = '1;
        repack();

        // Fairness stream of 10 cycles, drain, then a lone req0 (200/7) that wraps the pointer.
        for (int j = 0; j < 10; j++) begin
            t = (j + 3) % 4;
            tbl[j] = mk(4'hF, 4'hF, 4'(1 << (j % 4)), 1'b1, 2'(j % 4),
                        (j >= 5) ? 4'(1 << t) : 4'h0, qt[t], rt[t], 1'b0, 1'b0,
                        (j < 5) ? 3'(j) : 3'd5, 1'b0);
        end
        for (int j = 10; j < 15; j++) begin
            t = (j + 3) % 4;
            tbl[j] = mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'(1 << t), qt[t], rt[t],
                        1'b0, 1'b0, 3'(15 - j), 1'b0);
        end
        tbl[15] = mk(4'h1, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int j = 16; j < 20; j++)
            tbl[j] = mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[20] = mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h1, 5'd28, 4'd4, 1'b0, 1'b0, 3'd1, 1'b0);
        tbl[21] = mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1);

        #3;
        rst_chk("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int j = 0; j < 22; j++) apply(tbl[j], $sformatf("tbl%0d", j));

        // Back-pressure: tag 2 held at the output for 3 cycles while everyone requests.
        apply(mk(4'h4, 4'hF, 4'h4, 1'b1, 2'd2, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0), "bp0");
        apply(mk(4'h8, 4'hF, 4'h8, 1'b1, 2'd3, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd1, 1'b0), "bp1");
        for (int j = 2; j < 5; j++)
            apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd2, 1'b0),
                  $sformatf("bp%0d", j));
        for (int j = 5; j < 8; j++)
            apply(mk(4'hF, 4'hB, 4'h0, 1'b0, 2'd0, 4'h4, 5'd12, 4'd3, 1'b0, 1'b1, 3'd2, 1'b0),
                  $sformatf("bp_stall%0d", j));
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h4, 5'd12, 4'd3, 1'b0, 1'b0, 3'd2, 1'b0), "bp8");
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h8, 5'd11, 4'd7, 1'b0, 1'b0, 3'd1, 1'b0), "bp9");
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1), "bp10");

        // Divide by zero on req1 (45/0), followed directly by a normal req0 op.
        dvd_t[1] = 8'd45; dvs_t[1] = 4'd0;
        repack();
        apply(mk(4'h2, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0), "dz0");
        apply(mk(4'h1, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd1, 1'b0), "dz1");
        for (int j = 2; j < 5; j++)
            apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd2, 1'b0),
                  $sformatf("dz%0d", j));
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h2, 5'd31, 4'd13, 1'b1, 1'b0, 3'd2, 1'b0), "dz5");
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h1, 5'd28, 4'd4, 1'b0, 1'b0, 3'd1, 1'b0), "dz6");
        apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1), "dz7");
        dvd_t[1] = 8'd100; dvs_t[1] = 4'd9;
        repack();

        // Async reset with three ops in flight; pointer restarts at 0 afterwards.
        apply(mk(4'hF, 4'hF, 4'h2, 1'b1, 2'd1, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0), "ar0");
        apply(mk(4'hF, 4'hF, 4'h4, 1'b1, 2'd2, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd1, 1'b0), "ar1");
        apply(mk(4'hF, 4'hF, 4'h8, 1'b1, 2'd3, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd2, 1'b0), "ar2");
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("pre_reset inflight", 32'(inflight), 3);
        #1;
        rst_n = 1'b0;
        #1;
        rst_chk("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++)
            apply(mk(4'h0, 4'hF, 4'h0, 1'b0, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1),
                  $sformatf("post_reset%0d", j));
        apply(mk(4'hF, 4'hF, 4'h1, 1'b1, 2'd0, 4'h0, 5'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0), "post_reset_grant");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
